// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle CPU control sequencer (fetch/decode/exec/mem/wb/halt).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             reg_write,
  output logic             mem_write,
  output logic             step_ack,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] c_OP_STORE = 3'b110;
  localparam logic [2:0] c_OP_BZ    = 3'b111;

  state_t           state_q;
  logic             step_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             w_boundary;

  // A branch retires straight out of EXEC; everything else retires after MEM/WB.
  assign w_boundary = ((state_q == S_EXEC) && (op_q == c_OP_BZ)) ||
                      (state_q == S_MEM) || (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      step_q    <= 1'b0;
      op_q      <= 3'd0;
      retired_q <= '0;
    end else begin
      if (w_boundary) begin
        retired_q <= retired_q + 1'b1;
        if (step_q) begin
          step_q  <= 1'b0;
          state_q <= S_IDLE;
        end else if (halt_req) begin
          state_q <= S_HALT;
        end else if (run) begin
          state_q <= S_FETCH;
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run) begin
              state_q <= S_FETCH;
            end else if (step_req) begin
              state_q <= S_FETCH;
              step_q  <= 1'b1;
            end
          end
          S_FETCH:  state_q <= S_DECODE;
          S_DECODE: begin
            op_q    <= opcode;
            state_q <= S_EXEC;
          end
          S_EXEC:   state_q <= (op_q == c_OP_STORE) ? S_MEM : S_WB;
          S_HALT:   state_q <= S_HALT;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ir_write  = (state_q == S_FETCH);
  assign pc_inc    = (state_q == S_FETCH);
  assign pc_load   = (state_q == S_EXEC) && (op_q == c_OP_BZ) && zero;
  assign reg_write = (state_q == S_WB);
  assign mem_write = (state_q == S_MEM);
  assign step_ack  = w_boundary && step_q;
  assign halted    = (state_q == S_HALT);
  assign state     = state_q;
  assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed table-driven bench for cpu_sequencer (narrow counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  // Narrow counter keeps the wrap sequence short.
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, run, step_req, halt_req, zero;
  logic [2:0]       opcode;
  logic             ir_write, pc_inc, pc_load, reg_write, mem_write, step_ack, halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [6:0]       strobes;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req),
    .halt_req(halt_req), .opcode(opcode), .zero(zero),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load),
    .reg_write(reg_write), .mem_write(mem_write), .step_ack(step_ack),
    .halted(halted), .state(state), .retired(retired)
  );

  assign strobes = {ir_write, pc_inc, pc_load, reg_write, mem_write, step_ack, halted};

  typedef struct {
    logic       run;
    logic       step;
    logic       halt;
    logic [2:0] op;
    logic       zero;
    logic [2:0] st;
    logic [6:0] so;   // {ir_write,pc_inc,pc_load,reg_write,mem_write,step_ack,halted}
    logic [7:0] ret;
  } vec_t;

  vec_t tbl [27];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          run step halt op zero | st  strobes     ret
    tbl[0]  = '{0, 0, 0, 3'd0, 0, 3'd0, 7'b0000000, 8'd0};
    tbl[1]  = '{1, 0, 0, 3'd0, 0, 3'd0, 7'b0000000, 8'd0};
    tbl[2]  = '{1, 0, 0, 3'd0, 0, 3'd1, 7'b1100000, 8'd0};
    tbl[3]  = '{1, 0, 0, 3'd0, 0, 3'd2, 7'b0000000, 8'd0};
    tbl[4]  = '{1, 0, 0, 3'd0, 0, 3'd3, 7'b0000000, 8'd0};
    tbl[5]  = '{1, 0, 0, 3'd0, 0, 3'd5, 7'b0001000, 8'd0};
    tbl[6]  = '{1, 0, 0, 3'd7, 1, 3'd1, 7'b1100000, 8'd1};
    tbl[7]  = '{1, 0, 0, 3'd7, 1, 3'd2, 7'b0000000, 8'd1};
    tbl[8]  = '{1, 0, 0, 3'd7, 1, 3'd3, 7'b0010000, 8'd1};
    tbl[9]  = '{1, 0, 0, 3'd7, 0, 3'd1, 7'b1100000, 8'd2};
    tbl[10] = '{1, 0, 0, 3'd7, 0, 3'd2, 7'b0000000, 8'd2};
    tbl[11] = '{0, 0, 0, 3'd7, 0, 3'd3, 7'b0000000, 8'd2};
    tbl[12] = '{0, 1, 0, 3'd6, 0, 3'd0, 7'b0000000, 8'd3};
    tbl[13] = '{0, 1, 0, 3'd6, 0, 3'd1, 7'b1100000, 8'd3};
    tbl[14] = '{0, 0, 0, 3'd6, 0, 3'd2, 7'b0000000, 8'd3};
    tbl[15] = '{0, 0, 0, 3'd0, 1, 3'd3, 7'b0000000, 8'd3};
    tbl[16] = '{0, 0, 0, 3'd0, 0, 3'd4, 7'b0000110, 8'd3};
    tbl[17] = '{0, 0, 0, 3'd0, 0, 3'd0, 7'b0000000, 8'd4};
    tbl[18] = '{0, 0, 0, 3'd0, 0, 3'd0, 7'b0000000, 8'd4};
    tbl[19] = '{1, 1, 0, 3'd5, 0, 3'd0, 7'b0000000, 8'd4};
    tbl[20] = '{1, 0, 0, 3'd5, 0, 3'd1, 7'b1100000, 8'd4};
    tbl[21] = '{1, 0, 1, 3'd5, 0, 3'd2, 7'b0000000, 8'd4};
    tbl[22] = '{0, 0, 1, 3'd5, 0, 3'd3, 7'b0000000, 8'd4};
    tbl[23] = '{0, 0, 1, 3'd0, 0, 3'd5, 7'b0001000, 8'd4};
    tbl[24] = '{1, 0, 0, 3'd0, 0, 3'd6, 7'b0000001, 8'd5};
    tbl[25] = '{0, 1, 0, 3'd0, 0, 3'd6, 7'b0000001, 8'd5};
    tbl[26] = '{1, 0, 1, 3'd0, 0, 3'd6, 7'b0000001, 8'd5};

    reset = 1'b1; run = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    opcode = 3'd0; zero = 1'b0;
    tick();
    tick();
    chk("reset_state",   32'(state),   32'd0);
    chk("reset_strobes", 32'(strobes), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      run = tbl[i].run; step_req = tbl[i].step; halt_req = tbl[i].halt;
      opcode = tbl[i].op; zero = tbl[i].zero;
      #1;
      chk($sformatf("v%0d_state", i),   32'(state),   32'(tbl[i].st));
      chk($sformatf("v%0d_strobes", i), 32'(strobes), 32'(tbl[i].so));
      chk($sformatf("v%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
      tick();
    end

    // Reset out of HALT, then reset in the EXEC cycle of a STORE.
    run = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    reset = 1'b1;
    tick();
    chk("halt_rst_state",   32'(state),   32'd0);
    chk("halt_rst_strobes", 32'(strobes), 32'd0);
    chk("halt_rst_retired", 32'(retired), 32'd0);
    run = 1'b1;
    tick();
    chk("rst_hold_state", 32'(state), 32'd0);
    reset = 1'b0; opcode = 3'd6;
    for (int k = 0; k < 7; k++) tick();
    chk("store2_exec_state",   32'(state),   32'd3);
    chk("store2_exec_retired", 32'(retired), 32'd1);
    reset = 1'b1;
    tick();
    chk("exec_rst_state",   32'(state),   32'd0);
    chk("exec_rst_retired", 32'(retired), 32'd0);
    chk("exec_rst_strobes", 32'(strobes), 32'd0);
    reset = 1'b0; run = 1'b0;
    tick();
    chk("post_rst_state",   32'(state),   32'd0);
    chk("post_rst_strobes", 32'(strobes), 32'd0);

    // Counter wrap: back-to-back BZ, one retirement every 3 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b1; opcode = 3'd7; zero = 1'b0;
    for (int k = 1; k <= 770; k++) begin
      tick();
      if (k == 766) chk("wrap_pre_255",  32'(retired), 32'd255);
      if (k == 768) chk("wrap_last_255", 32'(retired), 32'd255);
      if (k == 769) chk("wrap_to_zero",  32'(retired), 32'd0);
      if (k == 770) chk("wrap_state",    32'(state),   32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
